fft_stream_ctrl: RTL

Parametrised stream-control block for the parallel FFT datapath: tracks input-valid beats through a fixed pipeline latency, produces the aligned output-valid strobe, and frames the output into N-point FFT frames of N/PAR beats each. It also generates a saturating warm-up `ready` flag, asserted LAT cycles after reset or clear. The block sits beside the FFT pipeline and drives output handshaking and frame markers to the downstream stage.

---
 rtl/fft_stream_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl
// Stream control beside the parallel FFT datapath. It delays input-valid by
// the pipeline latency, frames the output beats into N-point frames of N/PAR
// beats, counts completed frames and raises a warm-up ready flag LAT cycles
// after reset or clear.
module fft_stream_ctrl #(
    parameter  int N   = 128,
    parameter  int PAR = 4,
    parameter  int LAT = 16,
    parameter  int FW  = 8,
    localparam int BPF = N / PAR,
    localparam int IW  = $clog2(BPF),
    localparam int WW  = $clog2(LAT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_in_valid,
    output logic          o_out_valid,
    output logic [IW-1:0] o_out_idx,
    output logic          o_out_sof,
    output logic          o_out_eof,
    output logic [FW-1:0] o_frame_cnt,
    output logic          o_ready
);

    logic [LAT-1:0] r_vline;
    logic [IW-1:0]  r_idx;
    logic           r_sof;
    logic           r_eof;
    logic [FW-1:0]  r_frame_cnt;
    logic [WW-1:0]  r_warm_cnt;

    logic [LAT-1:0] w_shift;
    logic           w_next_valid;
    logic [IW-1:0]  w_next_idx;

    // Next contents of the valid delay line; stage 0 takes the new input bit.
    generate
        if (LAT == 1) begin : g_lat1
            assign w_shift = i_in_valid;
        end else begin : g_latn
            assign w_shift = {r_vline[LAT-2:0], i_in_valid};
        end
    endgenerate

    // The markers are computed one stage early so they register in step with out_valid.
    assign w_next_valid = w_shift[LAT-1];
    assign w_next_idx   = o_out_valid ? (r_idx + IW'(1)) : r_idx;

    // Valid delay line, beat index and frame markers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vline <= '0;
            r_idx   <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (i_clr) begin
            r_vline <= '0;
            r_idx   <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_vline <= w_shift;
            r_idx   <= w_next_idx;
            r_sof   <= w_next_valid && (w_next_idx == '0);
            r_eof   <= w_next_valid && (w_next_idx == IW'(BPF - 1));
        end
    end

    // Completed-frame counter; bumps on the edge that closes an eof beat, wraps silently.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
        end else if (i_clr) begin
            r_frame_cnt <= '0;
        end else if (r_eof) begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
        end
    end

    // Warm-up counter saturating at LAT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_warm_cnt <= '0;
        end else if (i_clr) begin
            r_warm_cnt <= '0;
        end else if (r_warm_cnt != WW'(LAT)) begin
            r_warm_cnt <= r_warm_cnt + WW'(1);
        end
    end

    assign o_out_valid = r_vline[LAT-1];
    assign o_out_idx   = r_idx;
    assign o_out_sof   = r_sof;
    assign o_out_eof   = r_eof;
    assign o_frame_cnt = r_frame_cnt;
    assign o_ready     = (r_warm_cnt == WW'(LAT));

endmodule
